// File: rtl/except_handler.sv
// Fetch-side exception handler: prioritises the fetch exception vector, records the
// trap in mepc/mcause/mtval, then flushes the pipeline and redirects to mtvec (or mepc on mret).
module except_handler #(
  parameter int             N         = 64,
  parameter logic [N-1:0]   MTVEC_RST = {N{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_F,
  input  logic [N-1:0]  PC_F,
  input  logic [3:0]    exceptF,
  input  logic          mret,
  input  logic          csrWe,
  input  logic [11:0]   csrAddr,
  input  logic [N-1:0]  csrWData,
  output logic [N-1:0]  csrRData,
  output logic          flush,
  output logic          redirect,
  output logic [N-1:0]  pcRedirect,
  input  logic          redirectAck,
  output logic          busy
);

  localparam logic [11:0] ADDR_MTVEC  = 12'h305;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FLUSH = 2'b01,
    REDIR = 2'b10
  } state_t;

  state_t         state_r;
  logic [N-1:0]   mtvec_r;
  logic [N-1:0]   mepc_r;
  logic [N-1:0]   mcause_r;
  logic [N-1:0]   mtval_r;
  logic [N-1:0]   tgt_r;
  logic           trap_s;
  logic           mret_s;

  // Fixed priority: breakpoint, page fault, access fault, misalign.
  function automatic logic [3:0] cause_of(input logic [3:0] exc);
    logic [3:0] c;
    if (exc[3]) begin
      c = 4'd3;
    end else if (exc[2]) begin
      c = 4'd12;
    end else if (exc[1]) begin
      c = 4'd1;
    end else begin
      c = 4'd0;
    end
    return c;
  endfunction

  assign trap_s = (state_r == IDLE) && valid_F && (exceptF != 4'b0000);
  assign mret_s = (state_r == IDLE) && !trap_s && mret;

  // Combinational CSR read port; unmapped addresses read as zero.
  always_comb begin
    csrRData = {N{1'b0}};
    case (csrAddr)
      ADDR_MTVEC:  csrRData = mtvec_r;
      ADDR_MEPC:   csrRData = mepc_r;
      ADDR_MCAUSE: csrRData = mcause_r;
      ADDR_MTVAL:  csrRData = mtval_r;
      default:     csrRData = {N{1'b0}};
    endcase
  end

  // CSR file, trap FSM and its registered outputs; trap updates come last so they win over csrWe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      flush      <= 1'b0;
      redirect   <= 1'b0;
      pcRedirect <= {N{1'b0}};
      busy       <= 1'b0;
      tgt_r      <= {N{1'b0}};
      mtvec_r    <= {MTVEC_RST[N-1:2], 2'b00};
      mepc_r     <= {N{1'b0}};
      mcause_r   <= {N{1'b0}};
      mtval_r    <= {N{1'b0}};
    end else begin
      if (csrWe) begin
        case (csrAddr)
          ADDR_MTVEC:  mtvec_r  <= {csrWData[N-1:2], 2'b00};
          ADDR_MEPC:   mepc_r   <= {csrWData[N-1:2], 2'b00};
          ADDR_MCAUSE: mcause_r <= csrWData;
          ADDR_MTVAL:  mtval_r  <= csrWData;
          default:     ;
        endcase
      end

      case (state_r)
        IDLE: begin
          if (trap_s) begin
            mepc_r   <= {PC_F[N-1:2], 2'b00};
            mcause_r <= {{(N-4){1'b0}}, cause_of(exceptF)};
            mtval_r  <= PC_F;
            tgt_r    <= mtvec_r;
            state_r  <= FLUSH;
            flush    <= 1'b1;
            busy     <= 1'b1;
          end else if (mret_s) begin
            tgt_r    <= mepc_r;
            state_r  <= FLUSH;
            flush    <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r  <= IDLE;
            flush    <= 1'b0;
            busy     <= 1'b0;
          end
        end
        FLUSH: begin
          state_r    <= REDIR;
          flush      <= 1'b0;
          redirect   <= 1'b1;
          pcRedirect <= tgt_r;
          busy       <= 1'b1;
        end
        REDIR: begin
          if (redirectAck) begin
            state_r  <= IDLE;
            redirect <= 1'b0;
            busy     <= 1'b0;
          end else begin
            state_r  <= REDIR;
            redirect <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          flush    <= 1'b0;
          redirect <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_handler.sv
// Self-checking bench for except_handler: directed vector table, hand-written corner
// sequences and randomised events checked against a transaction-level reference model.
module tb_except_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_F;
  logic [63:0] PC_F;
  logic [3:0]  exceptF;
  logic        mret;
  logic        csrWe;
  logic [11:0] csrAddr;
  logic [63:0] csrWData;
  logic [63:0] csrRData;
  logic        flush;
  logic        redirect;
  logic [63:0] pcRedirect;
  logic        redirectAck;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: architectural CSR contents
  logic [63:0] m_mtvec, m_mepc, m_mcause, m_mtval;

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic [3:0]  exc;
    logic        mr;
    int          ack_dly;
    logic        exp_ev;
    logic [63:0] exp_tgt;
    logic [63:0] exp_mepc;
    logic [63:0] exp_mcause;
    logic [63:0] exp_mtval;
  } vec_t;

  vec_t vecs[8];

  except_handler #(.N(64), .MTVEC_RST(64'h0)) dut (
    .clk(clk), .reset(reset), .valid_F(valid_F), .PC_F(PC_F), .exceptF(exceptF),
    .mret(mret), .csrWe(csrWe), .csrAddr(csrAddr), .csrWData(csrWData),
    .csrRData(csrRData), .flush(flush), .redirect(redirect), .pcRedirect(pcRedirect),
    .redirectAck(redirectAck), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_write(input logic [11:0] a, input logic [63:0] d);
    case (a)
      12'h305: m_mtvec  = d & ~64'h3;
      12'h341: m_mepc   = d & ~64'h3;
      12'h342: m_mcause = d;
      12'h343: m_mtval  = d;
      default: ;
    endcase
  endtask

  task automatic check_csrs(input string tag);
    logic [11:0] addrs[5];
    addrs = '{12'h305, 12'h341, 12'h342, 12'h343, 12'h300};
    for (int i = 0; i < 5; i++) begin
      csrAddr = addrs[i];
      #1;
      check($sformatf("%s csr[%h]", tag, addrs[i]), csrRData, model_read(addrs[i]));
    end
  endtask

  task automatic idle_inputs();
    valid_F = 1'b0; PC_F = 64'h0; exceptF = 4'b0000; mret = 1'b0;
    csrWe = 1'b0; csrWData = 64'h0; redirectAck = 1'b0;
  endtask

  task automatic junk_inputs();
    valid_F = 1'($urandom);
    PC_F    = {$urandom, $urandom};
    exceptF = 4'($urandom);
    mret    = 1'($urandom);
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    csrWe = 1'b1; csrAddr = a; csrWData = d;
    step();
    csrWe = 1'b0;
    model_write(a, d);
  endtask

  // Drive one IDLE-cycle event and check the flush / redirect / ack protocol.
  task automatic drive_event(input logic v, input logic [63:0] pc, input logic [3:0] ex,
                             input logic mr, input logic we, input logic [11:0] wa,
                             input logic [63:0] wd, input int ack_dly,
                             input logic exp_ev, input logic [63:0] exp_tgt, input string tag);
    valid_F = v; PC_F = pc; exceptF = ex; mret = mr;
    csrWe = we; csrAddr = wa; csrWData = wd;
    step();
    idle_inputs();
    if (!exp_ev) begin
      check({tag, " noev flush"}, 64'(flush), 64'h0);
      check({tag, " noev busy"}, 64'(busy), 64'h0);
      check({tag, " noev redirect"}, 64'(redirect), 64'h0);
      return;
    end
    check({tag, " flush"}, 64'(flush), 64'h1);
    check({tag, " busy@flush"}, 64'(busy), 64'h1);
    check({tag, " redirect@flush"}, 64'(redirect), 64'h0);
    junk_inputs();
    step();
    check({tag, " flush one cycle"}, 64'(flush), 64'h0);
    check({tag, " redirect"}, 64'(redirect), 64'h1);
    check({tag, " pcRedirect"}, pcRedirect, exp_tgt);
    for (int i = 0; i < ack_dly; i++) begin
      junk_inputs();
      step();
      check({tag, " redirect held"}, 64'(redirect), 64'h1);
      check({tag, " pcRedirect held"}, pcRedirect, exp_tgt);
      check({tag, " busy held"}, 64'(busy), 64'h1);
    end
    junk_inputs();
    redirectAck = 1'b1;
    step();
    idle_inputs();
    check({tag, " busy after ack"}, 64'(busy), 64'h0);
    check({tag, " redirect after ack"}, 64'(redirect), 64'h0);
  endtask

  // Expected behaviour derived from the model, then drive and compare.
  task automatic model_event(input logic v, input logic [63:0] pc, input logic [3:0] ex,
                             input logic mr, input logic we, input logic [11:0] wa,
                             input logic [63:0] wd, input int ack_dly, input string tag);
    logic [63:0] old_mtvec;
    logic [63:0] old_mepc;
    logic        ev;
    logic [63:0] tgt;
    old_mtvec = m_mtvec;
    old_mepc  = m_mepc;
    ev = 1'b0;
    tgt = 64'h0;
    if (we) model_write(wa, wd);
    if (v && ex != 4'b0000) begin
      ev = 1'b1;
      tgt = old_mtvec;
      m_mepc = pc & ~64'h3;
      m_mtval = pc;
      if (ex[3])      m_mcause = 64'd3;
      else if (ex[2]) m_mcause = 64'd12;
      else if (ex[1]) m_mcause = 64'd1;
      else            m_mcause = 64'd0;
    end else if (mr) begin
      ev = 1'b1;
      tgt = old_mepc;
    end
    drive_event(v, pc, ex, mr, we, wa, wd, ack_dly, ev, tgt, tag);
    check_csrs(tag);
  endtask

  initial begin
    logic [11:0] waddrs[5];
    waddrs = '{12'h305, 12'h341, 12'h342, 12'h343, 12'h300};
    idle_inputs();
    csrAddr = 12'h0;
    reset = 1'b1;
    m_mtvec = 64'h0; m_mepc = 64'h0; m_mcause = 64'h0; m_mtval = 64'h0;
    step();
    step();
    reset = 1'b0;
    check("rst flush", 64'(flush), 64'h0);
    check("rst redirect", 64'(redirect), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst pcRedirect", pcRedirect, 64'h0);
    check_csrs("rst");

    csr_write(12'h305, 64'h1003);
    check_csrs("mtvec wr");

    //            valid pc        exc     mr  ack ev  tgt       mepc      mcause  mtval
    vecs[0] = '{1'b1, 64'h2004, 4'b0001, 1'b0, 5, 1'b1, 64'h1000, 64'h2004, 64'd0,  64'h2004};
    vecs[1] = '{1'b0, 64'h0,    4'b0000, 1'b1, 0, 1'b1, 64'h2004, 64'h2004, 64'd0,  64'h2004};
    vecs[2] = '{1'b1, 64'h40,   4'b1111, 1'b0, 0, 1'b1, 64'h1000, 64'h40,   64'd3,  64'h40};
    vecs[3] = '{1'b1, 64'h7,    4'b0110, 1'b0, 1, 1'b1, 64'h1000, 64'h4,    64'd12, 64'h7};
    vecs[4] = '{1'b0, 64'h99,   4'b1111, 1'b0, 0, 1'b0, 64'h0,    64'h4,    64'd12, 64'h7};
    vecs[5] = '{1'b1, 64'h88,   4'b0000, 1'b0, 0, 1'b0, 64'h0,    64'h4,    64'd12, 64'h7};
    vecs[6] = '{1'b0, 64'h0,    4'b0000, 1'b1, 2, 1'b1, 64'h4,    64'h4,    64'd12, 64'h7};
    vecs[7] = '{1'b1, 64'h123,  4'b0010, 1'b1, 0, 1'b1, 64'h1000, 64'h120,  64'd1,  64'h123};

    for (int i = 0; i < 8; i++) begin
      drive_event(vecs[i].valid, vecs[i].pc, vecs[i].exc, vecs[i].mr, 1'b0, 12'h0, 64'h0,
                  vecs[i].ack_dly, vecs[i].exp_ev, vecs[i].exp_tgt, $sformatf("vec%0d", i));
      m_mepc = vecs[i].exp_mepc;
      m_mcause = vecs[i].exp_mcause;
      m_mtval = vecs[i].exp_mtval;
      check_csrs($sformatf("vec%0d", i));
    end

    // mtvec write in the trap-accept cycle: trap still targets the old mtvec
    model_event(1'b1, 64'h500, 4'b0001, 1'b0, 1'b1, 12'h305, 64'h3000, 0, "wr+trap mtvec");
    check("mtvec new value", m_mtvec, 64'h3000);
    // mcause write in the trap-accept cycle: trap value wins
    model_event(1'b1, 64'h604, 4'b0100, 1'b0, 1'b1, 12'h342, 64'hdead, 1, "wr+trap mcause");

    // Reset while waiting in REDIR
    valid_F = 1'b1; PC_F = 64'h700; exceptF = 4'b1000;
    step();
    idle_inputs();
    step();
    check("pre-reset redirect", 64'(redirect), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset@redir redirect", 64'(redirect), 64'h0);
    check("reset@redir busy", 64'(busy), 64'h0);
    check("reset@redir flush", 64'(flush), 64'h0);
    check("reset@redir pcRedirect", pcRedirect, 64'h0);
    m_mtvec = 64'h0; m_mepc = 64'h0; m_mcause = 64'h0; m_mtval = 64'h0;
    check_csrs("reset@redir");

    for (int i = 0; i < 60; i++) begin
      model_event(1'($urandom), {$urandom, $urandom}, 4'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), waddrs[$urandom_range(0, 4)],
                  {$urandom, $urandom}, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
